// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory responder.
// Covers the FSM state encoding, the request opcodes and the byte-to-word address offset.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // Number of byte-address bits below the word index for a given beat width.
    function automatic int addr_lsb(input int data_bits);
        return $clog2(data_bits / 8);
    endfunction

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for the memory responder.
// Provides one synchronous write port and one combinational read port; contents are not reset.
module mem_responder_array #(
    parameter int DEPTH     = 256,
    parameter int DATA_BITS = 64,
    parameter int IDX_BITS  = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 wr_en,
    input  logic [IDX_BITS-1:0]  wr_idx,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services one outstanding read/write burst at a time from an internal array.
// Define MEM_RESPONDER_ALIGN_CHECK_EN to reject requests whose address is not beat-aligned.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64,
    parameter int DEPTH         = 256,
    parameter int RD_LATENCY    = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    input  logic                     mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    output logic                     mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    input  logic                     mem_rd_ready,
    output logic                     busy,
    output logic                     err
);

    localparam int ADDR_LSB = addr_lsb(MEM_DATA_BITS);
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_BITS-1:0]     idx;
    logic [MEM_LEN_BITS:0]   remaining;
    logic [3:0]              lat_cnt;
    logic                    accept;
    logic                    beat_done;
    logic                    wr_en;
    logic                    proto_err;
    logic                    misaligned;
    logic                    last_beat;
    logic [MEM_DATA_BITS-1:0] rd_data;
    logic                    unused_addr;

    assign unused_addr = ^mem_req_addr;

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    localparam logic [MEM_ADDR_BITS-1:0] LSB_MASK =
        MEM_ADDR_BITS'((64'd1 << ADDR_LSB) - 64'd1);
    assign misaligned = |(mem_req_addr & LSB_MASK);
`else
    assign misaligned = 1'b0;
`endif

    assign last_beat = (remaining == (MEM_LEN_BITS+1)'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                idx       <= mem_req_addr[ADDR_LSB +: IDX_BITS];
                remaining <= {1'b0, mem_req_len} + 1'b1;
                lat_cnt   <= LAT_INIT;
            end else if (beat_done) begin
                idx       <= idx + 1'b1;
                remaining <= remaining - 1'b1;
            end
            if (state == RD_WAIT) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (proto_err) begin
                err <= 1'b1;
            end
        end
    end

    // Offending inputs only raise err; they never disturb the transfer in flight.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        beat_done  = 1'b0;
        wr_en      = 1'b0;
        proto_err  = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    if (misaligned) begin
                        proto_err = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (mem_req_opcode == OP_WR) begin
                            next_state = WR_DATA;
                        end else begin
                            next_state = (RD_LATENCY == 1) ? RD_DATA : RD_WAIT;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt <= 4'd1) begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                if (mem_rd_ready) begin
                    beat_done = 1'b1;
                    if (last_beat) begin
                        next_state = IDLE;
                    end
                end
            end
            WR_DATA: begin
                if (mem_wr_valid) begin
                    beat_done = 1'b1;
                    wr_en     = 1'b1;
                    if (last_beat) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (mem_req_valid && (state != IDLE)) begin
            proto_err = 1'b1;
        end
        if (mem_wr_valid && (state != WR_DATA)) begin
            proto_err = 1'b1;
        end
    end

    assign mem_rd_valid = (state == RD_DATA);
    assign mem_rd_bits  = (state == RD_DATA) ? rd_data : '0;
    assign busy         = (state != IDLE);

    mem_responder_array #(
        .DEPTH     (DEPTH),
        .DATA_BITS (MEM_DATA_BITS),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_idx  (idx),
        .wr_data (mem_wr_bits),
        .rd_idx  (idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder, built with RD_LATENCY=3.
// With MEM_RESPONDER_ALIGN_CHECK_EN defined it also exercises the misaligned-request drop.
module tb_mem_responder;
    import mem_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_bits;
    logic        mem_rd_ready;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic        rd_pat[$];

    mem_responder #(
        .MEM_LEN_BITS  (8),
        .MEM_ADDR_BITS (64),
        .MEM_DATA_BITS (64),
        .DEPTH         (256),
        .RD_LATENCY    (3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready),
        .busy           (busy),
        .err            (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge that ends the burst.
    task automatic write_burst(input logic [63:0] addr, input int len);
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_WR;
        mem_req_addr   = addr;
        mem_req_len    = 8'(len);
        @(negedge clock);
        mem_req_valid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            mem_wr_valid = 1'b1;
            mem_wr_bits  = wr_q[i];
            @(negedge clock);
        end
        mem_wr_valid = 1'b0;
        check($sformatf("wr_busy_done@%0h", addr), 64'(busy), 64'd0);
    endtask

    // Drives rd_ready from rd_pat (1 once empty) and checks every presented beat against exp_q.
    task automatic read_burst(input logic [63:0] addr, input int len, input bit inject);
        int beat;
        int cyc;
        bit seen;
        beat = 0;
        cyc  = 0;
        seen = 1'b0;
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_RD;
        mem_req_addr   = addr;
        mem_req_len    = 8'(len);
        while (beat <= len && cyc < 40) begin
            @(negedge clock);
            cyc++;
            mem_req_valid = 1'b0;
            mem_rd_ready  = 1'b0;
            if (mem_rd_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    check($sformatf("rd_latency@%0h", addr), 64'(cyc), 64'd3);
                    if (inject) begin
                        mem_req_valid  = 1'b1;
                        mem_req_opcode = OP_WR;
                        mem_req_addr   = 64'h40;
                        mem_req_len    = 8'd0;
                    end
                end
                check($sformatf("rd_beat%0d@%0h", beat, addr), mem_rd_bits, exp_q[beat]);
                mem_rd_ready = (rd_pat.size() > 0) ? rd_pat.pop_front() : 1'b1;
                if (mem_rd_ready) begin
                    got_q.push_back(mem_rd_bits);
                    beat++;
                end
            end
        end
        check($sformatf("rd_beats@%0h", addr), 64'(beat), 64'(len + 1));
        @(negedge clock);
        mem_req_valid = 1'b0;
        mem_rd_ready  = 1'b0;
        check($sformatf("rd_busy_done@%0h", addr), 64'(busy), 64'd0);
        check($sformatf("rd_valid_done@%0h", addr), 64'(mem_rd_valid), 64'd0);
    endtask

    initial begin
        int vcount;
        int wait_cyc;
        reset          = 1'b0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_rd_valid", 64'(mem_rd_valid), 64'd0);
        check("reset_rd_bits", mem_rd_bits, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        reset = 1'b1;
        @(negedge clock);

        $display("[TB] single write then read at 0x40");
        wr_q = '{64'h11};
        write_burst(64'h40, 0);
        exp_q = '{64'h11};
        read_burst(64'h40, 0, 1'b0);

        $display("[TB] add-by-one loop 0x0 -> 0x100");
        wr_q = '{64'd10, 64'd20, 64'd30, 64'd40};
        write_burst(64'h0, 3);
        exp_q = '{64'd10, 64'd20, 64'd30, 64'd40};
        got_q.delete();
        read_burst(64'h0, 3, 1'b0);
        wr_q.delete();
        foreach (got_q[i]) wr_q.push_back(got_q[i] + 64'd1);
        write_burst(64'h100, 3);
        exp_q = '{64'd11, 64'd21, 64'd31, 64'd41};
        read_burst(64'h100, 3, 1'b0);

        $display("[TB] burst read with backpressure");
        wr_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        write_burst(64'h08, 3);
        exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        rd_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        read_burst(64'h08, 3, 1'b0);

        $display("[TB] index wrap from 255 to 0");
        wr_q = '{64'hBEEF_0000, 64'hBEEF_0001};
        write_burst(64'h7F8, 1);
        exp_q = '{64'hBEEF_0001};
        read_burst(64'h0, 0, 1'b0);
        exp_q = '{64'hBEEF_0000};
        read_burst(64'h7F8, 0, 1'b0);
        check("err_clean", 64'(err), 64'd0);

        $display("[TB] request during read burst");
        exp_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
        read_burst(64'h08, 3, 1'b1);
        check("err_req_busy", 64'(err), 64'd1);
        exp_q = '{64'h11};
        read_burst(64'h40, 0, 1'b0);
        check("err_sticky", 64'(err), 64'd1);

        $display("[TB] write beat while idle");
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("err_cleared", 64'(err), 64'd0);
        mem_wr_valid = 1'b1;
        mem_wr_bits  = 64'hDEAD;
        @(negedge clock);
        mem_wr_valid = 1'b0;
        check("err_wr_idle", 64'(err), 64'd1);
        repeat (3) @(negedge clock);
        check("err_wr_idle_sticky", 64'(err), 64'd1);
        check("busy_wr_idle", 64'(busy), 64'd0);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        $display("[TB] misaligned read");
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_RD;
        mem_req_addr   = 64'h43;
        mem_req_len    = 8'd0;
        @(negedge clock);
        mem_req_valid = 1'b0;
        mem_rd_ready  = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_rd_valid) vcount++;
            @(negedge clock);
        end
        mem_rd_ready = 1'b0;
        check("align_no_beats", 64'(vcount), 64'd0);
        check("align_err", 64'(err), 64'd1);
        check("align_busy", 64'(busy), 64'd0);
`endif

        $display("[TB] reset in the middle of a read burst");
        mem_req_valid  = 1'b1;
        mem_req_opcode = OP_RD;
        mem_req_addr   = 64'h0;
        mem_req_len    = 8'd7;
        @(negedge clock);
        mem_req_valid = 1'b0;
        wait_cyc = 0;
        while (!mem_rd_valid && wait_cyc < 10) begin
            @(negedge clock);
            wait_cyc++;
        end
        check("rst_burst_started", 64'(mem_rd_valid), 64'd1);
        mem_rd_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_burst_mid", 64'(busy), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_rd_valid", 64'(mem_rd_valid), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        check("rst_async_err", 64'(err), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (mem_rd_valid) vcount++;
        end
        mem_rd_ready = 1'b0;
        check("rst_no_beats_after", 64'(vcount), 64'd0);
        check("rst_busy_after", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the accelerator memory request interface (mem_req/mem_wr/mem_rd).
- Services read and write requests from one initiator, e.g. the add-by-one compute engine, using an internal word array.
- Used as an on-chip scratch memory and as a self-contained memory model in tsim benches.
- Supports one outstanding request at a time, single- or multi-beat.

Parameters:
MEM_LEN_BITS, 8, width of mem_req_len (beats-1)
MEM_ADDR_BITS, 64, byte address width
MEM_DATA_BITS, 64, beat width; must be a power of two ≥ 8
DEPTH, 256, words of storage; power of two
RD_LATENCY, 1, cycles from request acceptance to first mem_rd_valid; range 1..15

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-low reset
mem_req_valid  in  1  request strobe, one cycle, no ready
mem_req_opcode  in  1  0=read, 1=write
mem_req_len  in  MEM_LEN_BITS  beats minus one
mem_req_addr  in  MEM_ADDR_BITS  byte address of first beat
mem_wr_valid  in  1  write beat strobe
mem_wr_bits  in  MEM_DATA_BITS  write beat data
mem_rd_valid  out  1  read beat valid
mem_rd_bits  out  MEM_DATA_BITS  read beat data
mem_rd_ready  in  1  initiator accepts read beat
busy  out  1  high whenever state != IDLE
err  out  1  sticky protocol-error flag, cleared only by reset

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; mem_rd_valid=0, mem_rd_bits=0, busy=0, err=0; beat counter and latency counter cleared. Array contents are not reset.
- Asserting reset mid-burst aborts the burst immediately. No further beats are produced. Writes already committed remain.
- Word index: idx = addr[ADDR_LSB +: log2(DEPTH)], where ADDR_LSB = log2(MEM_DATA_BITS/8).
  - Upper address bits are ignored, so addresses alias modulo DEPTH words.
  - Each beat advances idx by 1, wrapping from DEPTH-1 to 0.
- Beat count per request = mem_req_len+1; len=0 means one beat. Counter width is MEM_LEN_BITS+1.
- States:
  - IDLE:
    - req_valid & opcode=0: latch idx and len; load latency counter with RD_LATENCY-1. Go to RD_WAIT, or directly to RD_DATA if RD_LATENCY=1.
    - req_valid & opcode=1: latch idx and len; go to WR_DATA.
  - RD_WAIT: decrement the latency counter; go to RD_DATA when it reaches 0.
  - RD_DATA:
    - mem_rd_valid=1; mem_rd_bits = array[idx] (combinational read from the registered idx), held stable while mem_rd_ready=0.
    - On mem_rd_valid & mem_rd_ready: idx+1, remaining-1. The next beat is presented the following cycle with no bubble. The last beat returns to IDLE.
  - WR_DATA:
    - Each mem_wr_valid cycle writes mem_wr_bits to array[idx] at the clock edge; idx+1, remaining-1.
    - Last beat returns to IDLE.
    - The WR_DATA cycle immediately after acceptance may already carry a beat (zero wait).
- Timing: a request accepted at cycle T produces the first mem_rd_valid at T+RD_LATENCY.
- Back-to-back: a new request is accepted in the first IDLE cycle after the previous one completes.
- Protocol errors set err; the offending input is otherwise ignored:
  - mem_req_valid while state != IDLE (request dropped; current transfer continues).
  - mem_wr_valid in any state other than WR_DATA.
- Read-after-write to the same index in later requests returns the written value; there is no hazard because only one request is outstanding.

Optional Feature:
- Macro: MEM_RESPONDER_ALIGN_CHECK_EN
- Defined: a request whose addr[ADDR_LSB-1:0] != 0 sets err and is dropped; the state stays IDLE. For reads, no beats are returned.
- Not defined: low address bits are ignored (truncated to the word index) and no check logic is generated.

Decomposition:
- Shared package mem_responder_pkg:
  - state_t enum {IDLE, RD_WAIT, RD_DATA, WR_DATA}, logic [1:0]
  - opcode constants OP_RD=0, OP_WR=1
  - helper function computing ADDR_LSB from MEM_DATA_BITS
- One natural sub-module, mem_responder_array: DEPTH x MEM_DATA_BITS storage with one synchronous write port and one combinational read port. The FSM, counters and error logic stay in the top.

Test Plan:
- Reset: hold reset low 3 cycles mid-read-burst, then release → mem_rd_valid=0, busy=0, err=0 in the same cycle reset falls; no beats after release.
- Single write then read: write len=0, addr 0x40, data 0x0000_0000_0000_0011, then read addr 0x40 with RD_LATENCY=3 → mem_rd_valid at T+3 with 0x11; busy drops the cycle after the handshake.
- Compute-engine loop: drive the add-by-one initiator against this block with length=4, inp_baddr=0x0, out_baddr=0x100, preloaded 10,20,30,40 → words at 0x100..0x118 read 11,21,31,41.
- Burst with backpressure: read len=3 from addr 0x08, rd_ready pattern 1,0,0,1,1,0,1 → four beats of words 1..4 in order; rd_bits stable during stalls.
- Wrap: DEPTH=256, write len=1 at addr 0x7F8 (idx 255) → second beat lands at idx 0; reading addr 0x0 returns it.
- Errors: request while in RD_DATA, and mem_wr_valid in IDLE → err=1 and stays 1; the in-flight burst completes unchanged. With MEM_RESPONDER_ALIGN_CHECK_EN, a read at addr 0x43 → err=1 and no rd_valid.
